// File: rtl/shift_pkg.sv
// Shared encodings and default widths for the multicycle shift/rotate unit.
package shift_pkg;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    localparam logic [2:0] SH_SLL = 3'b000;
    localparam logic [2:0] SH_SRL = 3'b001;
    localparam logic [2:0] SH_SRA = 3'b010;
    localparam logic [2:0] SH_ROL = 3'b011;
    localparam logic [2:0] SH_ROR = 3'b100;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Encodings above SH_ROR are pass-through and never enter SHIFT.
    function automatic logic op_valid(input logic [2:0] op);
        return (op <= SH_ROR);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate of a W-bit word, selected by op.
module shift_step
    import shift_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic [2:0]   op,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    always_comb begin
        dout = din;
        case (op)
            SH_SLL:  dout = {din[W-2:0], 1'b0};
            SH_SRL:  dout = {1'b0, din[W-1:1]};
            SH_SRA:  dout = {din[W-1], din[W-1:1]};
            SH_ROL:  dout = {din[W-2:0], din[W-1]};
            SH_ROR:  dout = {din[0], din[W-1:1]};
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/shift_unit.sv
// Multicycle shift/rotate unit: one bit per clock, result held in acc with a done strobe.
module shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH   = shift_pkg::WIDTH,
    parameter int SHAMT_W = shift_pkg::SHAMT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   data_out
);

    // Handshake: start is accepted on any edge where the unit is in IDLE or DONE;
    // it is ignored while busy. done pulses for one cycle and data_out holds the
    // result until the next accepted start.
    logic [1:0]         state;
    logic [WIDTH-1:0]   acc;
    logic [SHAMT_W-1:0] cnt;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   step_out;

    shift_step #(.W(WIDTH)) u_step (
        .op   (op_q),
        .din  (acc),
        .dout (step_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            acc   <= '0;
            cnt   <= '0;
            op_q  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        acc   <= data_in;
                        cnt   <= shamt;
                        op_q  <= op;
                        state <= (shamt != '0 && op_valid(op)) ? ST_SHIFT : ST_DONE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    acc <= step_out;
                    cnt <= cnt - SHAMT_W'(1);
                    if (cnt == SHAMT_W'(1)) begin
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = (state == ST_SHIFT);
    assign done     = (state == ST_DONE);
    assign data_out = acc;

endmodule

// File: tb/tb_shift_unit.sv
// Directed and random checks of shift_unit latency, strobes and results.
module tb_shift_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] data_in = '0;
    logic [4:0]  shamt = '0;
    logic        busy;
    logic        done;
    logic [31:0] data_out;

    logic [31:0] exp_q[$];
    int          lat_q[$];
    int          checks = 0;
    int          errors = 0;

    shift_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .data_in  (data_in),
        .shamt    (shamt),
        .busy     (busy),
        .done     (done),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] d, input logic [2:0] o, input int n);
        case (o)
            3'd0: return d << n;
            3'd1: return d >> n;
            3'd2: return 32'($signed(d) >>> n);
            3'd3: return (n == 0) ? d : ((d << n) | (d >> (32 - n)));
            3'd4: return (n == 0) ? d : ((d >> n) | (d << (32 - n)));
            default: return d;
        endcase
    endfunction

    // Sets inputs and records what the DUT must eventually produce for them.
    task automatic present(input logic [31:0] d, input logic [2:0] o, input logic [4:0] n,
                           input logic [31:0] e);
        data_in = d;
        op      = o;
        shamt   = n;
        start   = 1'b1;
        exp_q.push_back(e);
        lat_q.push_back((n != 0 && o <= 3'd4) ? int'(n) + 1 : 1);
    endtask

    task automatic issue(input logic [31:0] d, input logic [2:0] o, input logic [4:0] n,
                         input logic [31:0] e, input bit hold);
        @(negedge clk);
        present(d, o, n, e);
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    // Entered just after the accepting edge; counts cycles until done.
    task automatic wait_done(input string tag, input bit post, input bit poke);
        int          cyc = 0;
        int          busy_n = 0;
        bit          got = 0;
        bit          overlap = 0;
        int          l;
        logic [31:0] e;
        l = lat_q.pop_front();
        e = exp_q.pop_front();
        repeat (40) begin
            @(negedge clk);
            cyc++;
            if (busy && done) overlap = 1;
            if (poke && cyc == 3) start = 1'b0;
            if (done) begin
                got = 1;
                break;
            end
            if (busy) busy_n++;
            if (poke && cyc == 2) begin
                data_in = 32'h1234_5678;
                op      = 3'd1;
                shamt   = 5'd3;
                start   = 1'b1;
            end
        end
        check({tag, "_latency"}, got ? cyc : 0, l);
        check({tag, "_busy_cycles"}, busy_n, l - 1);
        check({tag, "_result"}, data_out, e);
        check({tag, "_busy_done_overlap"}, 32'(overlap), 32'd0);
        if (post) begin
            @(negedge clk);
            check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
            check({tag, "_result_held"}, data_out, e);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [2:0]  ro;
        logic [4:0]  rn;
        bit          seen_done;

        // Reset state
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_data", data_out, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        issue(32'h0000_0001, 3'd0, 5'd4, 32'h0000_0010, 0);
        wait_done("sll4", 1, 0);
        issue(32'h8000_0000, 3'd2, 5'd31, 32'hFFFF_FFFF, 0);
        wait_done("sra31", 1, 0);
        issue(32'h8000_0000, 3'd1, 5'd31, 32'h0000_0001, 0);
        wait_done("srl31", 1, 0);
        issue(32'h0000_00F1, 3'd4, 5'd4, 32'h1000_000F, 0);
        wait_done("ror4", 1, 0);
        issue(32'hAB00_0000, 3'd3, 5'd8, 32'h0000_00AB, 0);
        wait_done("rol8", 1, 0);
        issue(32'hDEAD_BEEF, 3'd0, 5'd0, 32'hDEAD_BEEF, 0);
        wait_done("sll0", 1, 0);
        issue(32'hDEAD_BEEF, 3'd7, 5'd9, 32'hDEAD_BEEF, 0);
        wait_done("op111", 1, 0);

        // start pulsed mid-shift with other data must be ignored
        issue(32'h0000_00FF, 3'd0, 5'd8, 32'h0000_FF00, 0);
        wait_done("ignore_mid_start", 1, 1);

        // Back-to-back: start held through DONE launches the second op there
        issue(32'h0000_0003, 3'd0, 5'd2, 32'h0000_000C, 1);
        present(32'hF000_0000, 3'd2, 5'd3, 32'hFE00_0000);
        wait_done("b2b_first", 0, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("b2b_second", 1, 0);

        // Reset in the third SHIFT cycle of a 10-bit shift
        @(negedge clk);
        data_in = 32'h0000_0005;
        op      = 3'd0;
        shamt   = 5'd10;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_data", data_out, 32'd0);
        seen_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        reset = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        check("midreset_no_done", 32'(seen_done), 32'd0);
        issue(32'h1234_5678, 3'd3, 5'd16, 32'h5678_1234, 0);
        wait_done("after_reset", 1, 0);

        // Random operations against the arithmetic model
        for (int i = 0; i < 8; i++) begin
            rd = $urandom;
            ro = 3'($urandom_range(0, 7));
            rn = 5'($urandom_range(0, 31));
            issue(rd, ro, rn, model(rd, ro, int'(rn)), 0);
            wait_done("random", 1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
